// File: rtl/pingpong_ctrl_if.sv
// Bank-side bus of the ping-pong controller: shared write port and shared
// read address for two single-port-per-direction buffers A and B.
interface pingpong_ctrl_if #(
  parameter int AW = 7
);
  logic          wr_en_a;
  logic          wr_en_b;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          rd_en_a;
  logic          rd_en_b;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data_a;
  logic [15:0]   rd_data_b;

  modport master (
    output wr_en_a, wr_en_b, wr_addr, wr_data,
    output rd_en_a, rd_en_b, rd_addr,
    input  rd_data_a, rd_data_b
  );

  modport slave (
    input  wr_en_a, wr_en_b, wr_addr, wr_data,
    input  rd_en_a, rd_en_b, rd_addr,
    output rd_data_a, rd_data_b
  );
endinterface

// File: rtl/pingpong_ctrl.sv
// Ping-pong buffer controller. The writer fills bank A then bank B with
// incoming words; each full bank is streamed out by the reader while the
// writer fills the other. Words arriving while both banks are full are
// dropped and flagged by a sticky overflow bit. rd_hold freezes the reader
// (test hook used to force the writer into its wait state).
module pingpong_ctrl #(
  parameter int DEPTH = 100,
  parameter int AW    = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            data_en,
  input  logic [15:0]     data_in,
  input  logic            rd_hold,
  pingpong_ctrl_if.master bank,
  output logic [15:0]     dout,
  output logic            dout_vld,
  output logic            overflow
);

  typedef enum logic [1:0] {W_A, W_B, W_WAIT} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_A, R_B} rstate_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  wstate_t       w_state;
  rstate_t       r_state;
  logic          w_pend_b;   // bank the writer resumes with after W_WAIT
  logic          r_next_b;   // bank the reader serves next from R_IDLE
  logic [AW-1:0] wcnt;
  logic [AW-1:0] rcnt;
  logic          full_a, full_b;
  logic          set_a, set_b, clr_a, clr_b;

  logic          wr_en_a, wr_en_b, rd_en_a, rd_en_b;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [15:0]   wr_data;

  logic [1:0]    vld_pipe;   // rd_en delayed 1 and 2 cycles
  logic          sel_b_d;    // bank of the read issued one cycle earlier

  assign bank.wr_en_a = wr_en_a;
  assign bank.wr_en_b = wr_en_b;
  assign bank.wr_addr = wr_addr;
  assign bank.wr_data = wr_data;
  assign bank.rd_en_a = rd_en_a;
  assign bank.rd_en_b = rd_en_b;
  assign bank.rd_addr = rd_addr;
  assign dout_vld     = vld_pipe[1];

  // A bank becomes full on its last accepted word and empty on its last
  // issued read; the FSMs guarantee both never hit the same flag at once.
  assign set_a = (w_state == W_A) && data_en && (wcnt == LAST);
  assign set_b = (w_state == W_B) && data_en && (wcnt == LAST);
  assign clr_a = !rd_hold && (r_state == R_A) && (rcnt == LAST);
  assign clr_b = !rd_hold && (r_state == R_B) && (rcnt == LAST);

  // Bank full flags, set by the writer and cleared by the reader.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_a <= 1'b0;
      full_b <= 1'b0;
    end else begin
      if (set_a)      full_a <= 1'b1;
      else if (clr_a) full_a <= 1'b0;
      if (set_b)      full_b <= 1'b1;
      else if (clr_b) full_b <= 1'b0;
    end
  end

  // Write FSM: registered write strobes; a bank being cleared this very
  // cycle counts as free so the writer never loses a word to W_WAIT then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state  <= W_A;
      w_pend_b <= 1'b0;
      wcnt     <= '0;
      wr_en_a  <= 1'b0;
      wr_en_b  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      overflow <= 1'b0;
    end else begin
      wr_en_a <= 1'b0;
      wr_en_b <= 1'b0;
      case (w_state)
        W_A: if (data_en) begin
          wr_en_a <= 1'b1;
          wr_addr <= wcnt;
          wr_data <= data_in;
          if (wcnt == LAST) begin
            wcnt <= '0;
            if (full_b && !clr_b) begin
              w_state  <= W_WAIT;
              w_pend_b <= 1'b1;
            end else begin
              w_state  <= W_B;
            end
          end else begin
            wcnt <= wcnt + AW'(1);
          end
        end
        W_B: if (data_en) begin
          wr_en_b <= 1'b1;
          wr_addr <= wcnt;
          wr_data <= data_in;
          if (wcnt == LAST) begin
            wcnt <= '0;
            if (full_a && !clr_a) begin
              w_state  <= W_WAIT;
              w_pend_b <= 1'b0;
            end else begin
              w_state  <= W_A;
            end
          end else begin
            wcnt <= wcnt + AW'(1);
          end
        end
        default: begin
          // Both banks busy: drop the word, remember it happened.
          if (data_en) overflow <= 1'b1;
          if (w_pend_b ? !full_b : !full_a)
            w_state <= w_pend_b ? W_B : W_A;
        end
      endcase
    end
  end

  // Read FSM: issues address 0 on the edge it leaves R_IDLE so a full bank
  // drains in exactly DEPTH cycles, keeping pace with a continuous writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= R_IDLE;
      r_next_b <= 1'b0;
      rcnt     <= '0;
      rd_en_a  <= 1'b0;
      rd_en_b  <= 1'b0;
      rd_addr  <= '0;
    end else begin
      rd_en_a <= 1'b0;
      rd_en_b <= 1'b0;
      if (!rd_hold) begin
        case (r_state)
          R_A: begin
            rd_en_a <= 1'b1;
            rd_addr <= rcnt;
            if (rcnt == LAST) begin
              rcnt     <= '0;
              r_next_b <= 1'b1;
              r_state  <= full_b ? R_B : R_IDLE;
            end else begin
              rcnt <= rcnt + AW'(1);
            end
          end
          R_B: begin
            rd_en_b <= 1'b1;
            rd_addr <= rcnt;
            if (rcnt == LAST) begin
              rcnt     <= '0;
              r_next_b <= 1'b0;
              r_state  <= full_a ? R_A : R_IDLE;
            end else begin
              rcnt <= rcnt + AW'(1);
            end
          end
          default: begin
            if (!r_next_b && full_a) begin
              rd_en_a <= 1'b1;
              rd_addr <= '0;
              rcnt    <= AW'(1);
              r_state <= R_A;
            end else if (r_next_b && full_b) begin
              rd_en_b <= 1'b1;
              rd_addr <= '0;
              rcnt    <= AW'(1);
              r_state <= R_B;
            end
          end
        endcase
      end
    end
  end

  // Output stage: bank data arrives one cycle after rd_en, registered once
  // more into dout; the bank select travels alongside so a switch between
  // banks never picks the wrong return bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      sel_b_d  <= 1'b0;
      dout     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], rd_en_a | rd_en_b};
      sel_b_d  <= rd_en_b;
      if (vld_pipe[0]) dout <= sel_b_d ? bank.rd_data_b : bank.rd_data_a;
    end
  end

  a_rd_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_en_a && rd_en_b));
  a_wr_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en_a && wr_en_b));
  // A strobe visible now was decided on the previous edge; the bank must
  // not have been full at that point.
  a_no_wr_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    wr_en_a |-> !$past(full_a));
  a_no_wr_full_b: assert property (@(posedge clk) disable iff (!rst_n)
    wr_en_b |-> !$past(full_b));

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed bench for pingpong_ctrl with a two-bank memory model.
module tb_pingpong_ctrl;
  localparam int DEPTH = 100;
  localparam int AW    = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        data_en = 1'b0;
  logic        rd_hold = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] dout;
  logic        dout_vld;
  logic        overflow;

  int tests = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  pingpong_ctrl_if #(.AW(AW)) bif ();

  pingpong_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .data_en(data_en), .data_in(data_in),
    .rd_hold(rd_hold), .bank(bif), .dout(dout), .dout_vld(dout_vld),
    .overflow(overflow)
  );

  // Bank memories: synchronous write, read data one cycle after rd_en.
  logic [15:0] mem_a [2**AW];
  logic [15:0] mem_b [2**AW];
  always @(posedge clk) begin
    if (bif.wr_en_a) mem_a[bif.wr_addr] <= bif.wr_data;
    if (bif.wr_en_b) mem_b[bif.wr_addr] <= bif.wr_data;
    if (bif.rd_en_a) bif.rd_data_a <= mem_a[bif.rd_addr];
    if (bif.rd_en_b) bif.rd_data_b <= mem_b[bif.rd_addr];
  end

  // Observer: collects streamed words and bookkeeping, cleared by reset.
  logic [15:0] q [$];
  int cyc = 0, first_vld = -1, last_vld = -1, vld_cnt = 0;
  int wr_cnt = 0, wra_cnt = 0, wrb_cnt = 0, pipe_bad = 0;
  logic [1:0] hist = '0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      first_vld = -1; last_vld = -1; vld_cnt = 0;
      wr_cnt = 0; wra_cnt = 0; wrb_cnt = 0; pipe_bad = 0; hist = '0;
    end else begin
      if (dout_vld !== hist[1]) pipe_bad++;
      if (bif.rd_en_a && bif.rd_en_b) pipe_bad++;
      if (bif.wr_en_a && bif.wr_en_b) pipe_bad++;
      hist = {hist[0], bif.rd_en_a | bif.rd_en_b};
      if (dout_vld) begin
        q.push_back(dout);
        vld_cnt++;
        if (first_vld < 0) first_vld = cyc;
        last_vld = cyc;
      end
      if (bif.wr_en_a) begin wra_cnt++; wr_cnt++; end
      if (bif.wr_en_b) begin wrb_cnt++; wr_cnt++; end
    end
  end

  task automatic do_reset();
    data_en = 1'b0;
    rd_hold = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    data_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    outs = {bif.wr_en_a, bif.wr_en_b, bif.wr_addr, bif.wr_data, bif.rd_en_a,
            bif.rd_en_b, bif.rd_addr, dout, dout_vld, overflow};
    tests++;
    if (outs !== '0) begin errs++; $display("FAIL reset_outs: got %h expected 0", outs); end
    tests++;
    if ({dut.full_a, dut.full_b, dut.wcnt, dut.rcnt} !== '0) begin
      errs++; $display("FAIL reset_state: got %b expected 0", {dut.full_a, dut.full_b, dut.wcnt, dut.rcnt});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    outs = {bif.wr_en_a, bif.wr_en_b, bif.wr_addr, bif.wr_data, bif.rd_en_a,
            bif.rd_en_b, bif.rd_addr, dout, dout_vld, overflow};
    tests++;
    if (outs !== '0) begin errs++; $display("FAIL idle_outs: got %h expected 0", outs); end
  endtask

  task automatic test_continuous();
    int bad;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      data_en = 1'b1; data_in = 16'(i % 200);
      @(negedge clk);
    end
    idle(120);
    tests++;
    if (wr_cnt !== 400) begin errs++; $display("FAIL cont_writes: got %0d expected 400", wr_cnt); end
    tests++;
    if (overflow !== 1'b0) begin errs++; $display("FAIL cont_overflow: got %b expected 0", overflow); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_a[i] !== 16'(i)) bad++;
      if (mem_b[i] !== 16'(i + 100)) bad++;
    end
    tests++;
    if (bad !== 0) begin errs++; $display("FAIL cont_mem: got %0d bad words expected 0", bad); end
    tests++;
    if (q.size() !== 400) begin errs++; $display("FAIL cont_count: got %0d expected 400", q.size()); end
    bad = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== 16'(i % 200)) bad++;
    tests++;
    if (bad !== 0) begin errs++; $display("FAIL cont_data: got %0d bad words expected 0", bad); end
    tests++;
    if (last_vld - first_vld + 1 !== vld_cnt) begin
      errs++; $display("FAIL cont_gapless: got span %0d expected %0d", last_vld - first_vld + 1, vld_cnt);
    end
    tests++;
    if (pipe_bad !== 0) begin errs++; $display("FAIL cont_pipe: got %0d expected 0", pipe_bad); end
  endtask

  task automatic test_toggle();
    int bad;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      data_en = (i % 2 == 0); data_in = 16'(i / 2);
      @(negedge clk);
      if (i == 197) begin
        tests++;
        if (dut.full_a !== 1'b0) begin errs++; $display("FAIL tog_full_early: got %b expected 0", dut.full_a); end
      end
      if (i == 198) begin
        tests++;
        if (dut.full_a !== 1'b1) begin errs++; $display("FAIL tog_full_set: got %b expected 1", dut.full_a); end
      end
    end
    idle(120);
    tests++;
    if ({wra_cnt, wrb_cnt} !== {32'd100, 32'd0}) begin
      errs++; $display("FAIL tog_writes: got a=%0d b=%0d expected a=100 b=0", wra_cnt, wrb_cnt);
    end
    tests++;
    if (q.size() !== 100) begin errs++; $display("FAIL tog_count: got %0d expected 100", q.size()); end
    bad = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== 16'(i)) bad++;
    tests++;
    if (bad !== 0) begin errs++; $display("FAIL tog_data: got %0d bad words expected 0", bad); end
    tests++;
    if (last_vld - first_vld + 1 !== 100) begin
      errs++; $display("FAIL tog_gapless: got span %0d expected 100", last_vld - first_vld + 1);
    end
    tests++;
    if (dut.full_a !== 1'b0) begin errs++; $display("FAIL tog_full_clr: got %b expected 0", dut.full_a); end
  endtask

  task automatic test_stall();
    int bad;
    do_reset();
    rd_hold = 1'b1;
    for (int i = 0; i < 205; i++) begin
      data_en = 1'b1; data_in = (i < 200) ? 16'(i) : 16'(900 + i);
      @(negedge clk);
    end
    data_en = 1'b0;
    @(negedge clk);
    tests++;
    if (wr_cnt !== 200) begin errs++; $display("FAIL stall_dropped: got %0d writes expected 200", wr_cnt); end
    tests++;
    if (overflow !== 1'b1) begin errs++; $display("FAIL stall_overflow: got %b expected 1", overflow); end
    tests++;
    if (q.size() !== 0) begin errs++; $display("FAIL stall_noread: got %0d expected 0", q.size()); end
    rd_hold = 1'b0;
    idle(120);
    data_en = 1'b1; data_in = 16'd500;
    @(negedge clk);
    idle(100);
    tests++;
    if ({wr_cnt, wra_cnt} !== {32'd201, 32'd101}) begin
      errs++; $display("FAIL stall_resume: got total=%0d a=%0d expected 201/101", wr_cnt, wra_cnt);
    end
    tests++;
    if (mem_a[0] !== 16'd500) begin errs++; $display("FAIL stall_addr0: got %0d expected 500", mem_a[0]); end
    tests++;
    if (overflow !== 1'b1) begin errs++; $display("FAIL stall_sticky: got %b expected 1", overflow); end
    tests++;
    if (q.size() !== 200) begin errs++; $display("FAIL stall_count: got %0d expected 200", q.size()); end
    bad = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== 16'(i)) bad++;
    tests++;
    if (bad !== 0) begin errs++; $display("FAIL stall_data: got %0d bad words expected 0", bad); end
    tests++;
    if (last_vld - first_vld + 1 !== 200) begin
      errs++; $display("FAIL stall_gapless: got span %0d expected 200", last_vld - first_vld + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] outs;
    int first;
    logic [15:0] first_val;
    int bad;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      data_en = 1'b1; data_in = 16'(i);
      @(negedge clk);
    end
    tests++;
    if ({bif.wr_en_b, bif.wr_addr} !== {1'b1, 7'd49}) begin
      errs++; $display("FAIL mid_pre: got en=%b addr=%0d expected 1/49", bif.wr_en_b, bif.wr_addr);
    end
    data_in = 16'd150;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    outs = {bif.wr_en_a, bif.wr_en_b, bif.wr_addr, bif.wr_data, bif.rd_en_a,
            bif.rd_en_b, bif.rd_addr, dout, dout_vld, overflow};
    tests++;
    if (outs !== '0) begin errs++; $display("FAIL mid_async: got %h expected 0", outs); end
    tests++;
    if ({dut.full_a, dut.full_b, dut.wcnt} !== '0) begin
      errs++; $display("FAIL mid_state: got %b expected 0", {dut.full_a, dut.full_b, dut.wcnt});
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    first = -1;
    first_val = '0;
    for (int i = 0; i < 111; i++) begin
      data_en = 1'b1; data_in = 16'(1000 + i);
      @(negedge clk);
      if (i == 0) begin
        tests++;
        if ({bif.wr_en_a, bif.wr_en_b, bif.wr_addr, bif.wr_data} !== {1'b1, 1'b0, 7'd0, 16'd1000}) begin
          errs++; $display("FAIL mid_first_wr: got a=%b b=%b addr=%0d data=%0d expected 1/0/0/1000",
                           bif.wr_en_a, bif.wr_en_b, bif.wr_addr, bif.wr_data);
        end
      end
      if (dout_vld && first < 0) begin first = i; first_val = dout; end
    end
    idle(120);
    tests++;
    if (first !== 102) begin errs++; $display("FAIL mid_latency: got %0d expected 102", first); end
    tests++;
    if (first_val !== 16'd1000) begin errs++; $display("FAIL mid_first_dout: got %0d expected 1000", first_val); end
    tests++;
    if (q.size() !== 100) begin errs++; $display("FAIL mid_count: got %0d expected 100", q.size()); end
    bad = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== 16'(1000 + i)) bad++;
    tests++;
    if (bad !== 0) begin errs++; $display("FAIL mid_data: got %0d bad words expected 0", bad); end
    tests++;
    if (pipe_bad !== 0) begin errs++; $display("FAIL mid_pipe: got %0d expected 0", pipe_bad); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_toggle();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/pingpong_ctrl.md
PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 100, words per bank (2..1024).
REQ-002 SHALL have parameter AW, default 7, address width; 2^AW >= DEPTH.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_en  input  1  input word valid.
REQ-006 SHALL have port data_in  input  16  input word.
REQ-007 SHALL have ports wr_en_a / wr_en_b  output  1  write strobe, bank A / bank B.
REQ-008 SHALL have ports wr_addr  output  AW and wr_data  output  16, shared by both banks.
REQ-009 SHALL have ports rd_en_a / rd_en_b  output  1 and rd_addr  output  AW, bank read request.
REQ-010 SHALL have ports rd_data_a / rd_data_b  input  16; bank returns data 1 cycle after rd_en.
REQ-011 SHALL have ports dout  output  16 and dout_vld  output  1, streamed read data.
REQ-012 SHALL have port overflow  output  1, sticky flag for dropped input words.

Function
REQ-013 Write FSM SHALL have states W_A, W_B and W_WAIT; read FSM SHALL have states R_IDLE, R_A and R_B.
REQ-014 Each bank SHALL have a full flag, full_a / full_b.
REQ-015 Write side SHALL use registered outputs: in W_A/W_B with data_en=1, wr_en_x=1, wr_addr=wcnt and wr_data=data_in on the next cycle (latency 1).
REQ-016 wcnt SHALL increment per accepted word; with data_en=0, wcnt, wr_en and state SHALL hold.
REQ-017 On the accepted word with wcnt=DEPTH-1: wcnt SHALL become 0, the current bank's full flag SHALL be set, and the write FSM SHALL go to the other bank.
REQ-018 If the other bank's full flag is set and not being cleared that same cycle, the write FSM SHALL go to W_WAIT instead.
REQ-019 In W_WAIT, arriving words SHALL be dropped (no wr_en) and overflow SHALL be set.
REQ-020 The write FSM SHALL leave W_WAIT for the pending bank in the cycle its full flag is clear.
REQ-021 In R_IDLE, the read FSM SHALL go to R_A or R_B when that bank's full flag is set, taking bank A first after reset and strictly alternating thereafter.
REQ-022 Read side SHALL use registered outputs: in R_A/R_B, rd_en_x=1 and rd_addr=rcnt every cycle, rcnt counting 0..DEPTH-1.
REQ-023 At rcnt=DEPTH-1, the read FSM SHALL clear that bank's full flag in the same edge and go to the other bank's state if its flag is set, else to R_IDLE; there SHALL be no bubble between back-to-back banks.
REQ-024 Set and clear of the same flag in one cycle SHALL NOT occur by construction; flags for different banks SHALL update independently.
REQ-025 dout SHALL be the rd_data of the bank read at cycle N, registered; dout_vld SHALL be 1 at cycle N+2 for each rd_en at cycle N.
REQ-026 Bank select SHALL be delayed to match, so dout is never taken from the wrong bank across a switch.
REQ-027 rd_en_a and rd_en_b SHALL never both be 1; likewise wr_en_a and wr_en_b.
REQ-028 The block SHALL never write a bank whose full flag is set.
REQ-029 overflow SHALL clear only on reset.

Reset
REQ-030 On rst_n=0, all of the following SHALL go to 0 immediately and asynchronously: wr_en_a/b, rd_en_a/b, wr_addr, rd_addr, wr_data, dout, dout_vld, overflow, wcnt, rcnt, full_a and full_b.
REQ-031 On rst_n=0, write FSM SHALL be W_A, read FSM SHALL be R_IDLE, and next read bank SHALL be A.
REQ-032 Reset asserted mid-bank SHALL discard partial contents; after release, writing SHALL restart at bank A address 0.

Verification
REQ-033 Continuous data_en=1, data_in 0..199 wrapping, DEPTH=100 -> bank A gets 0..99 at addr 0..99, bank B gets 100..199; dout sequence 0,1,...,199,0,... contiguous with dout_vld=1 and no gaps once started; overflow stays 0.
REQ-034 data_en toggling 1/0 every cycle -> 100 writes to A over 200 cycles; full_a sets after the 100th accepted word; reader then streams A in 100 consecutive cycles.
REQ-035 Stall case: reader forced slow by holding bank readout (test hook or DEPTH=4 with full_b pre-held) -> write FSM enters W_WAIT; words dropped; overflow=1 stays after recovery.
REQ-036 Reader clears full_a in the same cycle the writer finishes B -> writer enters W_A directly, no W_WAIT, no dropped word.
REQ-037 rst_n pulsed low at wcnt=50 in bank B -> all outputs 0 asynchronously; after release, first wr_en_a with wr_addr=0; first dout after 100 new words.
REQ-038 Assertions: one-hot rd_en, one-hot wr_en, no write to a full bank, dout_vld count equals rd_en count delayed 2 cycles.
